// File: rtl/simple_logic_pkg.sv
// Shared definitions for the gate-bank checker: result bit positions, state
// encoding and the golden gate model.
package simple_logic_pkg;

   localparam int IDX_AND  = 0;
   localparam int IDX_OR   = 1;
   localparam int IDX_NAND = 2;
   localparam int IDX_NOR  = 3;
   localparam int IDX_XOR  = 4;
   localparam int IDX_XNOR = 5;
   localparam int IDX_NOT  = 6;

   typedef logic [6:0] gate_res_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } chk_state_t;

   function automatic gate_res_t golden(input logic a, input logic b);
      gate_res_t r;
      r           = '0;
      r[IDX_AND]  = a & b;
      r[IDX_OR]   = a | b;
      r[IDX_NAND] = ~(a & b);
      r[IDX_NOR]  = ~(a | b);
      r[IDX_XOR]  = a ^ b;
      r[IDX_XNOR] = ~(a ^ b);
      r[IDX_NOT]  = ~a;
      return r;
   endfunction

endpackage

// File: rtl/simple_logic_ref.sv
// Combinational golden model of the gate bank.
module simple_logic_ref
   import simple_logic_pkg::*;
(
   input  logic      a,
   input  logic      b,
   output gate_res_t exp_res
);

   assign exp_res = golden(a, b);

endmodule

// File: rtl/simple_logic_checker.sv
// Receive-side checker for the gate bank: 2-stage compare pipeline, saturating
// counters, {a,b} coverage and first-mismatch capture under an IDLE/RUN/DONE FSM.
module simple_logic_checker
   import simple_logic_pkg::*;
#(
   parameter int CNT_W      = 16,
   parameter int MIN_CHECKS = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             in_valid,
   input  logic             in_a,
   input  logic             in_b,
   input  logic [6:0]       in_res,
   output logic             busy,
   output logic             done,
   output logic             err_pulse,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] chk_count,
   output logic [3:0]       cov_mask,
   output logic             first_err_valid,
   output logic [1:0]       first_err_ab,
   output logic [6:0]       first_err_diff
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] MIN_C   = CNT_W'(MIN_CHECKS);

   chk_state_t state;

   // vld_pipe[0]: stage-1 register holds a sample; vld_pipe[1]: stage-2 register does
   logic [1:0] vld_pipe;
   logic       s1_a, s1_b;
   gate_res_t  s1_res;
   logic [1:0] s2_ab;
   gate_res_t  s2_diff;
   gate_res_t  exp_res;

   logic accept, start_ok, done_cond, s2_err;

   simple_logic_ref u_ref (
      .a       (s1_a),
      .b       (s1_b),
      .exp_res (exp_res)
   );

   assign accept    = (state == RUN) && in_valid;
   assign start_ok  = start && (state != RUN);
   assign done_cond = (cov_mask == 4'hF) && (chk_count >= MIN_C);
   assign s2_err    = |s2_diff;

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         vld_pipe        <= '0;
         s1_a            <= 1'b0;
         s1_b            <= 1'b0;
         s1_res          <= '0;
         s2_ab           <= '0;
         s2_diff         <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
         err_pulse       <= 1'b0;
         err_count       <= '0;
         chk_count       <= '0;
         cov_mask        <= '0;
         first_err_valid <= 1'b0;
         first_err_ab    <= '0;
         first_err_diff  <= '0;
      end else begin
         vld_pipe  <= {vld_pipe[0], accept};
         s1_a      <= in_a;
         s1_b      <= in_b;
         s1_res    <= in_res;
         s2_ab     <= {s1_a, s1_b};
         s2_diff   <= s1_res ^ exp_res;
         err_pulse <= 1'b0;

         if (start_ok) begin
            // a new run discards anything still in the pipeline
            vld_pipe        <= '0;
            err_count       <= '0;
            chk_count       <= '0;
            cov_mask        <= '0;
            first_err_valid <= 1'b0;
            first_err_ab    <= '0;
            first_err_diff  <= '0;
            state           <= RUN;
            busy            <= 1'b1;
            done            <= 1'b0;
         end else begin
            if (vld_pipe[1]) begin
               if (chk_count != CNT_MAX) chk_count <= chk_count + 1'b1;
               cov_mask[s2_ab] <= 1'b1;
               if (s2_err) begin
                  err_pulse <= 1'b1;
                  if (err_count != CNT_MAX) err_count <= err_count + 1'b1;
                  if (!first_err_valid) begin
                     first_err_valid <= 1'b1;
                     first_err_ab    <= s2_ab;
                     first_err_diff  <= s2_diff;
                  end
               end
            end
            if ((state == RUN) && done_cond) begin
               state <= DONE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_simple_logic_checker.sv
// Scoreboard bench for simple_logic_checker: samples are queued with their due
// edge when accepted; a negedge monitor retires them and compares every output.
module tb_simple_logic_checker;

   localparam int MIN  = 4;
   localparam int MAXC = 65535;

   logic clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0, in_a = 1'b0, in_b = 1'b0;
   logic [6:0] in_res = '0;
   logic busy, done, err_pulse, first_err_valid;
   logic [15:0] err_count, chk_count;
   logic [3:0] cov_mask;
   logic [1:0] first_err_ab;
   logic [6:0] first_err_diff;

   logic s_start = 1'b0, s_valid = 1'b0;
   logic [6:0] s_res = '0;
   logic s_busy, s_done, s_pulse, s_fv;
   logic [2:0] s_err, s_chk;
   logic [3:0] s_cov;
   logic [1:0] s_fab;
   logic [6:0] s_fdiff;

   int n_chk = 0, n_err = 0;

   simple_logic_checker #(.CNT_W(16), .MIN_CHECKS(MIN)) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
      .in_res(in_res), .busy(busy), .done(done), .err_pulse(err_pulse), .err_count(err_count),
      .chk_count(chk_count), .cov_mask(cov_mask), .first_err_valid(first_err_valid),
      .first_err_ab(first_err_ab), .first_err_diff(first_err_diff));

   simple_logic_checker #(.CNT_W(3), .MIN_CHECKS(4)) dut_s (
      .clk(clk), .rst(rst), .start(s_start), .in_valid(s_valid), .in_a(1'b0), .in_b(1'b0),
      .in_res(s_res), .busy(s_busy), .done(s_done), .err_pulse(s_pulse), .err_count(s_err),
      .chk_count(s_chk), .cov_mask(s_cov), .first_err_valid(s_fv),
      .first_err_ab(s_fab), .first_err_diff(s_fdiff));

   always #5 clk = ~clk;

   // expected results straight from the gate truth table
   function automatic logic [6:0] gold(input logic a, input logic b);
      case ({a, b})
         2'b00:   return 7'b1101100;
         2'b01:   return 7'b1010110;
         2'b10:   return 7'b0010110;
         default: return 7'b0100011;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- scoreboard / reference model ----------------
   typedef struct {
      int         due;
      logic [1:0] ab;
      logic [6:0] diff;
   } item_t;
   item_t q[$];

   int cyc = 0;
   logic c_rst = 1'b1, c_start = 1'b0, c_vld = 1'b0, c_a = 1'b0, c_b = 1'b0;
   logic [6:0] c_res = '0;

   int m_state = 0;  // 0 idle, 1 run, 2 done
   int m_chk = 0, m_err = 0;
   logic [3:0] m_cov = '0;
   logic m_fv = 1'b0, m_pulse = 1'b0;
   logic [1:0] m_fab = '0;
   logic [6:0] m_fdiff = '0;

   always @(posedge clk) begin
      cyc++;
      c_rst = rst; c_start = start; c_vld = in_valid;
      c_a = in_a; c_b = in_b; c_res = in_res;
   end

   always @(negedge clk) begin
      int    old;
      bit    cond, have;
      item_t it;
      old  = m_state;
      cond = (m_cov == 4'hF) && (m_chk >= MIN);
      have = 0;
      m_pulse = 1'b0;
      if (c_rst) begin
         q.delete();
         m_state = 0; m_chk = 0; m_err = 0; m_cov = '0; m_fv = 0; m_fab = '0; m_fdiff = '0;
      end else begin
         if (q.size() > 0 && q[0].due == cyc) begin
            it = q.pop_front();
            have = 1;
         end
         if (c_start && old != 1) begin
            q.delete();
            m_state = 1; m_chk = 0; m_err = 0; m_cov = '0; m_fv = 0; m_fab = '0; m_fdiff = '0;
         end else begin
            if (have) begin
               m_chk = (m_chk < MAXC) ? m_chk + 1 : MAXC;
               m_cov[it.ab] = 1'b1;
               if (it.diff != 0) begin
                  m_pulse = 1'b1;
                  m_err = (m_err < MAXC) ? m_err + 1 : MAXC;
                  if (!m_fv) begin
                     m_fv = 1'b1; m_fab = it.ab; m_fdiff = it.diff;
                  end
               end
            end
            if (old == 1 && cond) m_state = 2;
            if (old == 1 && c_vld)
               q.push_back('{due: cyc + 2, ab: {c_a, c_b}, diff: c_res ^ gold(c_a, c_b)});
         end
      end
      chk("busy", busy, m_state == 1);
      chk("done", done, m_state == 2);
      chk("err_pulse", err_pulse, m_pulse);
      chk("chk_count", chk_count, m_chk);
      chk("err_count", err_count, m_err);
      chk("cov_mask", cov_mask, m_cov);
      chk("first_err_valid", first_err_valid, m_fv);
      chk("first_err_ab", first_err_ab, m_fab);
      chk("first_err_diff", first_err_diff, m_fdiff);
   end

   // ---------------- stimulus ----------------
   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1; tick(); start = 1'b0;
   endtask

   task automatic send(input logic a, input logic b, input logic [6:0] bad);
      in_valid = 1'b1; in_a = a; in_b = b; in_res = gold(a, b) ^ bad;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_done(input int lim);
      for (int i = 0; i < lim; i++) begin
         if (done) break;
         tick();
      end
      chk("done_reached", done, 1);
   endtask

   initial begin
      tick(3);
      rst = 1'b0;
      tick();

      // 1: full coverage, all correct
      pulse_start();
      for (int i = 0; i < 4; i++) send(i[1], i[0], 7'd0);
      wait_done(20);
      chk("t1_chk", chk_count, 4);
      chk("t1_err", err_count, 0);

      // 2: nand bit corrupted on {1,1}
      pulse_start();
      send(0, 0, 0); send(1, 0, 0); send(0, 1, 0); send(1, 1, 7'b0000100);
      wait_done(20);
      chk("t2_err", err_count, 1);
      chk("t2_fab", first_err_ab, 2'b11);
      chk("t2_fdiff", first_err_diff, 7'b0000100);

      // 3: back-to-back 00 only, then the rest
      pulse_start();
      repeat (8) send(0, 0, 0);
      tick(3);
      chk("t3_busy", busy, 1);
      chk("t3_chk", chk_count, 8);
      chk("t3_cov", cov_mask, 4'b0001);
      send(0, 1, 0); send(1, 0, 0); send(1, 1, 0);
      wait_done(20);

      // 4: in_valid ignored in DONE and IDLE; restart from DONE
      repeat (3) send(1, 1, 7'h7F);
      tick(3);
      pulse_start();
      chk("t4_busy", busy, 1);
      chk("t4_cleared", chk_count, 0);
      rst = 1'b1; tick(); rst = 1'b0;
      repeat (3) send(0, 1, 7'h01);
      tick(3);

      // 5: reset with two mismatching samples in flight
      pulse_start();
      send(0, 0, 7'h10); send(1, 1, 7'h02);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("t5_busy", busy, 0);
      chk("t5_chk", chk_count, 0);
      tick(5);

      // random runs, some with an ignored start during RUN
      for (int r = 0; r < 30; r++) begin
         logic [3:0] icov;
         int icnt;
         icov = '0; icnt = 0;
         pulse_start();
         while (!(icov == 4'hF && icnt >= MIN) && icnt < 200) begin
            logic [1:0] ab;
            logic [6:0] bad;
            tick($urandom_range(0, 2));
            if ($urandom_range(0, 9) == 0) pulse_start();
            ab  = 2'($urandom_range(0, 3));
            bad = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(1, 127)) : 7'd0;
            send(ab[1], ab[0], bad);
            icov[ab] = 1'b1;
            icnt++;
         end
         wait_done(20);
         if ($urandom_range(0, 1) == 1) send(1, 0, 7'h40);
      end

      // 6: 3-bit counters saturate without wrapping
      s_start = 1'b1; tick(); s_start = 1'b0;
      s_valid = 1'b1; s_res = 7'b1101100 ^ 7'h01;
      tick(10);
      s_valid = 1'b0;
      tick(4);
      chk("t6_err_sat", s_err, 7);
      chk("t6_chk_sat", s_chk, 7);
      chk("t6_busy", s_busy, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
